// File: rtl/pc_sequencer_pkg.sv
// Shared constants and next-PC select encoding for the fetch PC sequencer.
package pc_sequencer_pkg;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h8000_0180;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JR,
    SEL_J,
    SEL_EXC,
    SEL_FAULT
  } next_pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: saturating count, oldest entry overwritten when full.
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                top_ptr;
  logic [CW-1:0]                count;

  assign top_ptr = wr_ptr - PW'(1);
  assign valid   = (count != '0);
  assign top     = valid ? mem[top_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && pop && valid) begin
      mem[top_ptr] <= push_addr;
    end else if (push) begin
      // wr_ptr wraps onto the oldest slot once full, so a push overwrites it
      mem[wr_ptr] <= push_addr;
      wr_ptr      <= wr_ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && valid) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised next-PC select, target alignment check and RAS.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      EXC_VEC   = EXC_VEC_DEFAULT,
  parameter int               RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Exception,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] JRTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              RasPush,
  input  logic [ADDR_W-1:0] RasPushAddr,
  input  logic              RasPop,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlusInc,
  output logic [ADDR_W-1:0] RasTop,
  output logic              RasValid,
  output logic              AlignFault,
  output logic [ADDR_W-1:0] FaultAddr
);
  localparam logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  next_pc_sel_t      sel;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              flush;

  assign PCPlusInc = PC + ADDR_W'(INC);

  always_comb begin
    sel = SEL_SEQ;
    tgt = '0;
    if (Exception)        sel = SEL_EXC;
    else if (BranchTaken) begin sel = SEL_BR; tgt = BranchTarget; end
    else if (JumpReg)     begin sel = SEL_JR; tgt = JRTarget;     end
    else if (Jump)        begin sel = SEL_J;  tgt = JumpTarget;   end
    else if (Stall)       sel = SEL_HOLD;
    // only explicit redirect targets are alignment-checked
    if ((sel == SEL_BR || sel == SEL_JR || sel == SEL_J) && ((tgt & ALIGN_MASK) != '0))
      sel = SEL_FAULT;
  end

  always_comb begin
    next_pc = PCPlusInc;
    case (sel)
      SEL_HOLD:              next_pc = PC;
      SEL_BR, SEL_JR, SEL_J: next_pc = tgt;
      SEL_EXC, SEL_FAULT:    next_pc = EXC_PC;
      default:               next_pc = PCPlusInc;
    endcase
  end

  assign flush = (sel == SEL_EXC) || (sel == SEL_FAULT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC         <= RESET_PC;
      AlignFault <= 1'b0;
      FaultAddr  <= '0;
    end else begin
      PC         <= next_pc;
      AlignFault <= (sel == SEL_FAULT);
      if (sel == SEL_FAULT) FaultAddr <= tgt;
    end
  end

  pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (Clk),
    .rst_n     (Reset),
    .flush     (flush),
    .push      (RasPush && !Stall),
    .pop       (RasPop && !Stall),
    .push_addr (RasPushAddr),
    .top       (RasTop),
    .valid     (RasValid)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer against a queue-based next-PC/RAS model.
module tb_pc_sequencer;
  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Exception, BranchTaken, JumpReg, Jump, RasPush, RasPop;
  logic [31:0] BranchTarget, JRTarget, JumpTarget, RasPushAddr;
  logic [31:0] PC, PCPlusInc, RasTop, FaultAddr;
  logic        RasValid, AlignFault;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_af;
  logic [31:0] m_fa;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Exception(Exception),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpReg(JumpReg), .JRTarget(JRTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .RasPush(RasPush), .RasPushAddr(RasPushAddr), .RasPop(RasPop),
    .PC(PC), .PCPlusInc(PCPlusInc), .RasTop(RasTop), .RasValid(RasValid),
    .AlignFault(AlignFault), .FaultAddr(FaultAddr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_af = 1'b0;
    m_fa = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] npc, tgt;
    logic        redirect, flush;
    redirect = 1'b0;
    flush    = 1'b0;
    tgt      = 32'h0;
    if (Exception) begin npc = EXC; flush = 1'b1; end
    else if (BranchTaken) begin tgt = BranchTarget; redirect = 1'b1; end
    else if (JumpReg)     begin tgt = JRTarget;     redirect = 1'b1; end
    else if (Jump)        begin tgt = JumpTarget;   redirect = 1'b1; end
    else npc = Stall ? m_pc : m_pc + 32'd4;
    m_af = 1'b0;
    if (redirect) begin
      if (tgt % 4 != 0) begin
        npc = EXC; flush = 1'b1; m_af = 1'b1; m_fa = tgt;
      end else npc = tgt;
    end
    if (flush) m_ras.delete();
    else if (!Stall) begin
      if (RasPush && RasPop && m_ras.size() > 0) m_ras[m_ras.size()-1] = RasPushAddr;
      else if (RasPush) begin
        m_ras.push_back(RasPushAddr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (RasPop && m_ras.size() > 0) void'(m_ras.pop_back());
    end
    m_pc = npc;
  endtask

  task automatic idle();
    Stall = 0; Exception = 0; BranchTaken = 0; JumpReg = 0; Jump = 0;
    RasPush = 0; RasPop = 0;
    BranchTarget = 0; JRTarget = 0; JumpTarget = 0; RasPushAddr = 0;
  endtask

  // one clock: inputs already applied; returns at the following negedge
  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("pc", PC, m_pc);
      chk("pc_plus_inc", PCPlusInc, m_pc + 32'd4);
      chk("ras_valid", {31'h0, RasValid}, {31'h0, m_ras.size() != 0});
      chk("ras_top", RasTop, (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'h0);
      chk("align_fault", {31'h0, AlignFault}, {31'h0, m_af});
      chk("fault_addr", FaultAddr, m_fa);
    end
  end

  initial begin
    idle();
    Reset = 1'b0;
    model_reset();
    #3;
    chk("reset_pc", PC, 32'h0);
    chk("reset_af", {31'h0, AlignFault}, 32'h0);
    chk("reset_ras", {31'h0, RasValid}, 32'h0);
    @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;

    // 1: sequential fetch
    repeat (3) tick();
    chk("t1_pc12", PC, 32'd12);
    chk("t1_inc", PCPlusInc, 32'd16);

    // 2: stall then branch under stall
    tick();
    chk("t2_pc10", PC, 32'h10);
    Stall = 1;
    repeat (2) tick();
    chk("t2_hold", PC, 32'h10);
    BranchTaken = 1; BranchTarget = 32'h40;
    tick();
    idle();
    chk("t2_br", PC, 32'h40);

    // 3: exception beats branch, clears RAS
    RasPush = 1; RasPushAddr = 32'h123;
    tick();
    chk("t3_push", RasTop, 32'h123);
    RasPush = 0;
    Exception = 1; BranchTaken = 1; BranchTarget = 32'h40;
    tick();
    idle();
    chk("t3_exc", PC, EXC);
    chk("t3_ras", {31'h0, RasValid}, 32'h0);

    // 4: misaligned jump
    Jump = 1; JumpTarget = 32'h102;
    tick();
    idle();
    chk("t4_pc", PC, EXC);
    chk("t4_af", {31'h0, AlignFault}, 32'h1);
    chk("t4_fa", FaultAddr, 32'h102);
    tick();
    chk("t4_af_pulse", {31'h0, AlignFault}, 32'h0);
    chk("t4_fa_hold", FaultAddr, 32'h102);

    // 5: RAS overflow, pops, push+pop
    RasPush = 1;
    for (int i = 0; i < 5; i++) begin
      RasPushAddr = 32'hA + i;
      tick();
    end
    RasPush = 0;
    chk("t5_top", RasTop, 32'hE);
    RasPop = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_pop", RasTop, 32'hE - i);
      tick();
    end
    chk("t5_empty", {31'h0, RasValid}, 32'h0);
    tick();
    chk("t5_pop5_valid", {31'h0, RasValid}, 32'h0);
    chk("t5_pop5_top", RasTop, 32'h0);
    RasPop = 0; RasPush = 1; RasPushAddr = 32'h1;
    tick();
    RasPushAddr = 32'h2;
    tick();
    RasPop = 1; RasPushAddr = 32'h3;
    tick();
    chk("t5_replace", RasTop, 32'h3);
    RasPush = 0;
    tick();
    RasPop = 0;
    chk("t5_after", RasTop, 32'h1);

    // 6: wrap then async reset mid-cycle
    Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    tick();
    idle();
    chk("t6_top_pc", PC, 32'hFFFF_FFFC);
    chk("t6_inc_wrap", PCPlusInc, 32'h0);
    tick();
    chk("t6_wrap", PC, 32'h0);
    chk("t6_nofault", {31'h0, AlignFault}, 32'h0);
    repeat (3) tick();
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("t6_async_pc", PC, 32'h0);
    chk("t6_async_ras", {31'h0, RasValid}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    chk("t6_after_rst", PC, 32'h4);

    // random phase
    for (int n = 0; n < 2000; n++) begin
      Stall        = ($urandom_range(99) < 30);
      Exception    = ($urandom_range(99) < 3);
      BranchTaken  = ($urandom_range(99) < 10);
      JumpReg      = ($urandom_range(99) < 6);
      Jump         = ($urandom_range(99) < 6);
      BranchTarget = $urandom & (($urandom_range(9) < 8) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      JRTarget     = $urandom & (($urandom_range(9) < 8) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      JumpTarget   = $urandom & (($urandom_range(9) < 8) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      RasPush      = ($urandom_range(99) < 35);
      RasPop       = ($urandom_range(99) < 30);
      RasPushAddr  = $urandom;
      tick();
    end
    idle();
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
